// File: rtl/picorv32_axi_pkg.sv
// Shared types and constants for the PicoRV32 native-to-AXI4-Lite bridge.
package picorv32_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA,
        DONE,
        DRAIN
    } bridge_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [2:0] PROT_INSTR = 3'b100;

    // SLVERR and DECERR both have the upper bit set; OKAY/EXOKAY do not.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/picorv32_axi_wdog.sv
// Transaction watchdog: counts enabled cycles and flags the cycle that reaches the limit.
module picorv32_axi_wdog #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_eff;

    // A clear in the first cycle of a state makes that cycle count as number one.
    assign count_eff = clear ? '0 : count_q;
    assign expire    = (TIMEOUT_CYCLES > 0) && enable && (count_eff == LIMIT);

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (enable)
            count_q <= count_eff + CW'(1);
        else
            count_q <= '0;
    end

endmodule

// File: rtl/picorv32_axi_bridge.sv
// Bridges the PicoRV32 native memory interface onto an AXI4-Lite master, one transaction at a time.
module picorv32_axi_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_axi_awvalid,
    input  logic                    mem_axi_awready,
    output logic [ADDR_WIDTH-1:0]   mem_axi_awaddr,
    output logic [2:0]              mem_axi_awprot,
    output logic                    mem_axi_wvalid,
    input  logic                    mem_axi_wready,
    output logic [DATA_WIDTH-1:0]   mem_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_axi_wstrb,
    input  logic                    mem_axi_bvalid,
    output logic                    mem_axi_bready,
    input  logic [1:0]              mem_axi_bresp,
    output logic                    mem_axi_arvalid,
    input  logic                    mem_axi_arready,
    output logic [ADDR_WIDTH-1:0]   mem_axi_araddr,
    output logic [2:0]              mem_axi_arprot,
    input  logic                    mem_axi_rvalid,
    output logic                    mem_axi_rready,
    input  logic [DATA_WIDTH-1:0]   mem_axi_rdata,
    input  logic [1:0]              mem_axi_rresp,
    input  logic                    mem_valid,
    input  logic                    mem_instr,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_error,
    output logic                    busy
);
    import picorv32_axi_pkg::*;

    bridge_state_t           state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    instr_q;
    logic                    is_write_q;
    logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                    ready_q, error_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    wdog_clear_q;
    logic                    wdog_enable, wdog_expire, completing;

    assign wdog_enable = state_q inside {WRITE, WRESP, RADDR, RDATA};
    assign completing  = (state_q == WRESP && mem_axi_bvalid) || (state_q == RDATA && mem_axi_rvalid);

    picorv32_axi_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .enable (wdog_enable),
        .clear  (wdog_clear_q),
        .expire (wdog_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            instr_q      <= 1'b0;
            is_write_q   <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            rdata_q      <= '0;
            wdog_clear_q <= 1'b0;
        end else begin
            wdog_clear_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid) begin
                        addr_q       <= mem_addr;
                        wdata_q      <= mem_wdata;
                        wstrb_q      <= mem_wstrb;
                        instr_q      <= mem_instr;
                        is_write_q   <= |mem_wstrb;
                        wdog_clear_q <= 1'b1;
                        if (|mem_wstrb) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WRITE;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RADDR;
                        end
                    end
                end
                // AW and W complete independently; leave once neither is still pending.
                WRITE: begin
                    if (mem_axi_awready) awvalid_q <= 1'b0;
                    if (mem_axi_wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || mem_axi_awready) && (!wvalid_q || mem_axi_wready)) begin
                        bready_q     <= 1'b1;
                        wdog_clear_q <= 1'b1;
                        state_q      <= WRESP;
                    end
                end
                WRESP: begin
                    if (mem_axi_bvalid) begin
                        bready_q <= 1'b0;
                        error_q  <= resp_is_error(mem_axi_bresp);
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                RADDR: begin
                    if (mem_axi_arready) begin
                        arvalid_q    <= 1'b0;
                        rready_q     <= 1'b1;
                        wdog_clear_q <= 1'b1;
                        state_q      <= RDATA;
                    end
                end
                RDATA: begin
                    if (mem_axi_rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= mem_axi_rdata;
                        error_q  <= resp_is_error(mem_axi_rresp);
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    state_q <= IDLE;
                end
                // The CPU has already been answered; just retire the abandoned AXI transaction.
                DRAIN: begin
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    if (mem_axi_awready) awvalid_q <= 1'b0;
                    if (mem_axi_wready)  wvalid_q  <= 1'b0;
                    if (mem_axi_arready) arvalid_q <= 1'b0;
                    if ((bready_q && mem_axi_bvalid) || (rready_q && mem_axi_rvalid)) begin
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A genuine response in the expiry cycle wins over the timeout.
            if (wdog_expire && !completing) begin
                ready_q  <= 1'b1;
                error_q  <= 1'b1;
                rdata_q  <= '1;
                bready_q <= is_write_q;
                rready_q <= !is_write_q;
                state_q  <= DRAIN;
            end
        end
    end

    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = addr_q;
    assign mem_axi_awprot  = PROT_DATA;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_wstrb   = wstrb_q;
    assign mem_axi_bready  = bready_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = addr_q;
    assign mem_axi_arprot  = instr_q ? PROT_INSTR : PROT_DATA;
    assign mem_axi_rready  = rready_q;
    assign mem_ready       = ready_q;
    assign mem_rdata       = rdata_q;
    assign mem_error       = error_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_picorv32_axi_bridge.sv
// Scoreboard bench for picorv32_axi_bridge: 32-bit instance with an 8-cycle watchdog, 64-bit instance without.
module tb_picorv32_axi_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_rready;
    logic        mem_axi_awready = 1'b0, mem_axi_wready = 1'b0, mem_axi_bvalid = 1'b0;
    logic        mem_axi_arready = 1'b0, mem_axi_rvalid = 1'b0;
    logic [31:0] mem_axi_awaddr, mem_axi_araddr, mem_axi_wdata;
    logic [2:0]  mem_axi_awprot, mem_axi_arprot;
    logic [3:0]  mem_axi_wstrb;
    logic [1:0]  mem_axi_bresp = 2'b00, mem_axi_rresp = 2'b00;
    logic [31:0] mem_axi_rdata = 32'h0;
    logic        mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready, mem_error, busy;
    logic [31:0] mem_rdata;

    logic        d64_awvalid, d64_wvalid, d64_bready, d64_arvalid, d64_rready;
    logic        d64_awready = 1'b0, d64_wready = 1'b0, d64_bvalid = 1'b0;
    logic        d64_arready = 1'b0, d64_rvalid = 1'b0;
    logic [31:0] d64_awaddr, d64_araddr;
    logic [63:0] d64_wdata;
    logic [2:0]  d64_awprot, d64_arprot;
    logic [7:0]  d64_wstrb;
    logic [1:0]  d64_bresp = 2'b00, d64_rresp = 2'b00;
    logic [63:0] d64_rdata_in = 64'h0;
    logic        d64_valid = 1'b0, d64_instr = 1'b0;
    logic [31:0] d64_addr = 32'h0;
    logic [63:0] d64_wdata_in = 64'h0;
    logic [7:0]  d64_wstrb_in = 8'h0;
    logic        d64_ready, d64_error, d64_busy;
    logic [63:0] d64_rdata;

    picorv32_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
        .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
        .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready), .mem_axi_bresp(mem_axi_bresp),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
        .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
        .mem_axi_rdata(mem_axi_rdata), .mem_axi_rresp(mem_axi_rresp),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error), .busy(busy)
    );

    picorv32_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(0)) dut64 (
        .clk(clk), .reset(reset),
        .mem_axi_awvalid(d64_awvalid), .mem_axi_awready(d64_awready),
        .mem_axi_awaddr(d64_awaddr), .mem_axi_awprot(d64_awprot),
        .mem_axi_wvalid(d64_wvalid), .mem_axi_wready(d64_wready),
        .mem_axi_wdata(d64_wdata), .mem_axi_wstrb(d64_wstrb),
        .mem_axi_bvalid(d64_bvalid), .mem_axi_bready(d64_bready), .mem_axi_bresp(d64_bresp),
        .mem_axi_arvalid(d64_arvalid), .mem_axi_arready(d64_arready),
        .mem_axi_araddr(d64_araddr), .mem_axi_arprot(d64_arprot),
        .mem_axi_rvalid(d64_rvalid), .mem_axi_rready(d64_rready),
        .mem_axi_rdata(d64_rdata_in), .mem_axi_rresp(d64_rresp),
        .mem_valid(d64_valid), .mem_instr(d64_instr), .mem_addr(d64_addr),
        .mem_wdata(d64_wdata_in), .mem_wstrb(d64_wstrb_in),
        .mem_ready(d64_ready), .mem_rdata(d64_rdata), .mem_error(d64_error), .busy(d64_busy)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_rdata = 32'h0;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pushExpected(input string tag, input logic [31:0] rdata, input logic error);
        exp_t e;
        e.tag   = tag;
        e.rdata = rdata;
        e.error = error;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic instr);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = instr;
    endtask

    // Every completion pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ready", {63'b0, mem_ready}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.tag, "_rdata"}, {32'b0, mem_rdata}, {32'b0, e.rdata});
                checkOutput({e.tag, "_error"}, {63'b0, mem_error}, {63'b0, e.error});
            end
        end
    end

    // order: 0 = AW accepted first, 1 = W accepted first, 2 = both together
    task automatic runWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input logic [1:0] bresp);
        pushExpected("wr", last_rdata, bresp[1]);
        applyStimulus(addr, data, strb, 1'b0);
        tick();
        checkOutput("wr_awvalid", mem_axi_awvalid, 1);
        checkOutput("wr_wvalid", mem_axi_wvalid, 1);
        checkOutput("wr_awaddr", mem_axi_awaddr, addr);
        checkOutput("wr_wdata", mem_axi_wdata, data);
        checkOutput("wr_wstrb", mem_axi_wstrb, strb);
        checkOutput("wr_awprot", mem_axi_awprot, 3'b000);
        checkOutput("wr_busy", busy, 1);
        mem_valid = 1'b0;
        mem_axi_awready = (order == 0 || order == 2);
        mem_axi_wready  = (order == 1 || order == 2);
        tick();
        if (order != 2) begin
            checkOutput("wr_first_dropped", (order == 0) ? mem_axi_awvalid : mem_axi_wvalid, 0);
            checkOutput("wr_other_held", (order == 0) ? mem_axi_wvalid : mem_axi_awvalid, 1);
            checkOutput("wr_bready_early", mem_axi_bready, 0);
            mem_axi_awready = (order == 1);
            mem_axi_wready  = (order == 0);
            tick();
        end
        checkOutput("wr_aw_done", mem_axi_awvalid, 0);
        checkOutput("wr_w_done", mem_axi_wvalid, 0);
        checkOutput("wr_bready", mem_axi_bready, 1);
        mem_axi_awready = 1'b0;
        mem_axi_wready  = 1'b0;
        mem_axi_bvalid  = 1'b1;
        mem_axi_bresp   = bresp;
        tick();
        checkOutput("wr_ready_pulse", mem_ready, 1);
        checkOutput("wr_bready_drop", mem_axi_bready, 0);
        mem_axi_bvalid = 1'b0;
        tick();
        checkOutput("wr_ready_one_cycle", mem_ready, 0);
        checkOutput("wr_idle", busy, 0);
    endtask

    task automatic runRead(input logic [31:0] addr, input logic instr, input logic [31:0] data,
                           input logic [1:0] rresp);
        pushExpected("rd", data, rresp[1]);
        last_rdata = data;
        applyStimulus(addr, 32'h0, 4'h0, instr);
        tick();
        checkOutput("rd_arvalid", mem_axi_arvalid, 1);
        checkOutput("rd_araddr", mem_axi_araddr, addr);
        checkOutput("rd_arprot", mem_axi_arprot, instr ? 3'b100 : 3'b000);
        checkOutput("rd_no_aw", mem_axi_awvalid, 0);
        mem_valid = 1'b0;
        mem_axi_arready = 1'b1;
        tick();
        checkOutput("rd_ar_done", mem_axi_arvalid, 0);
        checkOutput("rd_rready", mem_axi_rready, 1);
        mem_axi_arready = 1'b0;
        mem_axi_rvalid  = 1'b1;
        mem_axi_rdata   = data;
        mem_axi_rresp   = rresp;
        tick();
        checkOutput("rd_ready_pulse", mem_ready, 1);
        checkOutput("rd_rready_drop", mem_axi_rready, 0);
        mem_axi_rvalid = 1'b0;
        mem_axi_rdata  = ~data;
        tick();
        checkOutput("rd_ready_one_cycle", mem_ready, 0);
        checkOutput("rd_rdata_stable", mem_rdata, data);
        checkOutput("rd_idle", busy, 0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valids", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid}, 3'b000);
        checkOutput("rst_readies", {mem_axi_bready, mem_axi_rready}, 2'b00);
        checkOutput("rst_ready", {mem_ready, mem_error}, 2'b00);
        checkOutput("rst_rdata", mem_rdata, 32'h0);
        reset = 1'b0;
        tick();

        runWrite(32'h100, 32'hDEADBEEF, 4'hF, 0, 2'b00);
        runRead(32'h200, 1'b1, 32'h12345678, 2'b00);
        runRead(32'h204, 1'b0, 32'hCAFEF00D, 2'b10);
        runWrite(32'h108, 32'h55AA55AA, 4'h3, 1, 2'b11);
        runWrite(32'h10C, 32'hA5A5_0001, 4'h8, 2, 2'b00);

        // Watchdog: arready withheld, the CPU is answered after 8 cycles in RADDR.
        pushExpected("timeout", 32'hFFFF_FFFF, 1'b1);
        last_rdata = 32'hFFFF_FFFF;
        applyStimulus(32'h300, 32'h0, 4'h0, 1'b0);
        tick();
        checkOutput("to_arvalid", mem_axi_arvalid, 1);
        mem_valid = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            tick();
            checkOutput("to_no_early_ready", mem_ready, 0);
        end
        tick();
        checkOutput("to_ready", mem_ready, 1);
        checkOutput("to_error", mem_error, 1);
        checkOutput("to_arvalid_held", mem_axi_arvalid, 1);
        tick();
        checkOutput("to_ready_drop", mem_ready, 0);
        checkOutput("to_drain_busy", busy, 1);
        checkOutput("to_drain_arvalid", mem_axi_arvalid, 1);
        checkOutput("to_drain_rready", mem_axi_rready, 1);
        mem_axi_arready = 1'b1;
        tick();
        checkOutput("to_ar_done", mem_axi_arvalid, 0);
        checkOutput("to_still_draining", busy, 1);
        mem_axi_arready = 1'b0;
        mem_axi_rvalid  = 1'b1;
        mem_axi_rdata   = 32'h0BADF00D;
        tick();
        mem_axi_rvalid = 1'b0;
        checkOutput("to_idle", busy, 0);
        checkOutput("to_rdata_kept", mem_rdata, 32'hFFFF_FFFF);

        // 64-bit write with upper-lane strobes only.
        d64_valid    = 1'b1;
        d64_addr     = 32'h400;
        d64_wdata_in = 64'h0123_4567_89AB_CDEF;
        d64_wstrb_in = 8'hF0;
        tick();
        d64_valid = 1'b0;
        checkOutput("w64_valids", {d64_awvalid, d64_wvalid}, 2'b11);
        checkOutput("w64_wdata", d64_wdata, 64'h0123_4567_89AB_CDEF);
        checkOutput("w64_wstrb", d64_wstrb, 8'hF0);
        checkOutput("w64_awaddr", d64_awaddr, 32'h400);
        d64_awready = 1'b1;
        d64_wready  = 1'b1;
        tick();
        checkOutput("w64_bready", d64_bready, 1);
        d64_awready = 1'b0;
        d64_wready  = 1'b0;
        d64_bvalid  = 1'b1;
        tick();
        checkOutput("w64_ready", {d64_ready, d64_error}, 2'b10);
        d64_bvalid = 1'b0;
        tick();
        checkOutput("w64_idle", {d64_ready, d64_busy}, 2'b00);

        // Reset lands while the read is waiting in RDATA, with rvalid arriving at the same edge.
        pushExpected("rst_rd", 32'h7777_7777, 1'b0);
        applyStimulus(32'h500, 32'h0, 4'h0, 1'b1);
        tick();
        mem_valid = 1'b0;
        mem_axi_arready = 1'b1;
        tick();
        checkOutput("rr_in_rdata", mem_axi_rready, 1);
        mem_axi_arready = 1'b0;
        mem_axi_rvalid  = 1'b1;
        mem_axi_rdata   = 32'h7777_7777;
        reset = 1'b1;
        exp_q.delete();
        last_rdata = 32'h0;
        tick();
        checkOutput("rr_ready", {mem_ready, mem_error}, 2'b00);
        checkOutput("rr_handshake", {mem_axi_rready, mem_axi_arvalid, mem_axi_bready}, 3'b000);
        checkOutput("rr_busy", busy, 0);
        checkOutput("rr_rdata", mem_rdata, 32'h0);
        checkOutput("rr_addr_prot", {mem_axi_araddr, mem_axi_arprot}, 35'h0);
        reset = 1'b0;
        mem_axi_rvalid = 1'b0;
        tick();
        checkOutput("rr_no_pulse", mem_ready, 0);
        checkOutput("rr_idle", busy, 0);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/picorv32_axi_bridge.md
PICORV32_AXI_BRIDGE -- requirements
Module: picorv32_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI and native address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, legal values 32 or 64: data width on both sides; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0: watchdog limit in cycles; 0 disables the watchdog.
REQ-004 SHALL have ports `clk` (in, 1, sole clock) and `reset` (in, 1); one clock, reset synchronous and active-high.
REQ-005 SHALL have AXI write-address ports: `mem_axi_awvalid` (out, 1), `mem_axi_awready` (in, 1), `mem_axi_awaddr` (out, ADDR_WIDTH), `mem_axi_awprot` (out, 3).
REQ-006 SHALL have AXI write-data ports: `mem_axi_wvalid` (out, 1), `mem_axi_wready` (in, 1), `mem_axi_wdata` (out, DATA_WIDTH), `mem_axi_wstrb` (out, DATA_WIDTH/8).
REQ-007 SHALL have AXI write-response ports: `mem_axi_bvalid` (in, 1), `mem_axi_bready` (out, 1), `mem_axi_bresp` (in, 2).
REQ-008 SHALL have AXI read-address ports: `mem_axi_arvalid` (out, 1), `mem_axi_arready` (in, 1), `mem_axi_araddr` (out, ADDR_WIDTH), `mem_axi_arprot` (out, 3).
REQ-009 SHALL have AXI read-data ports: `mem_axi_rvalid` (in, 1), `mem_axi_rready` (out, 1), `mem_axi_rdata` (in, DATA_WIDTH), `mem_axi_rresp` (in, 2).
REQ-010 SHALL have native request ports: `mem_valid` (in, 1), `mem_instr` (in, 1), `mem_addr` (in, ADDR_WIDTH), `mem_wdata` (in, DATA_WIDTH), `mem_wstrb` (in, DATA_WIDTH/8).
REQ-011 SHALL have native response ports: `mem_ready` (out, 1, one-cycle completion pulse), `mem_rdata` (out, DATA_WIDTH), `mem_error` (out, 1, valid while mem_ready=1).
REQ-012 SHALL have port `busy` (out, 1): high in any state except IDLE.

Function
REQ-013 SHALL implement states IDLE, WRITE, WRESP, RADDR, RDATA, DONE, DRAIN.
REQ-014 SHALL, in IDLE with mem_valid=1, register addr/wdata/wstrb/instr and go to WRITE if |mem_wstrb, else RADDR.
REQ-015 SHALL drive all AXI address/data/strobe/prot outputs from these registers only.
REQ-016 SHALL, in WRITE, assert awvalid and wvalid independently, each deasserting after its own handshake; go to WRESP once both handshakes are done, whether they occur simultaneously or in either order.
REQ-017 SHALL, in WRESP, assert bready; on bvalid capture error=bresp[1] and go to DONE.
REQ-018 SHALL, in RADDR, assert arvalid until arready, then go to RDATA.
REQ-019 SHALL, in RDATA, assert rready; on rvalid capture rdata and error=rresp[1], then go to DONE.
REQ-020 SHALL hold mem_ready=1 for exactly one cycle in DONE, then return to IDLE; completion latency is B/R handshake cycle N -> mem_ready in cycle N+1.
REQ-021 SHALL drive awprot=3'b000, and arprot=3'b100 when instr=1, else 3'b000.
REQ-022 SHALL never deassert an AXI valid before its ready.
REQ-023 SHALL accept no new request in DONE or DRAIN (mem_valid ignored).
REQ-024 SHALL, when TIMEOUT_CYCLES>0, count cycles spent in WRITE/WRESP/RADDR/RDATA, clearing the count on each state entry.
REQ-025 SHALL, when the count reaches TIMEOUT_CYCLES, pulse mem_ready with mem_error=1 and mem_rdata all-ones, then enter DRAIN.
REQ-026 SHALL, in DRAIN, keep any unaccepted valids asserted, hold bready/rready high, and return to IDLE after the outstanding response handshake.
REQ-027 SHALL hold mem_rdata stable between read completions.

Reset
REQ-028 SHALL, on reset, go to IDLE and clear all valids, bready, rready, mem_ready, mem_error, busy, the timeout counter and mem_rdata to 0.
REQ-029 SHALL apply reset mid-transaction immediately, with no completion pulse.

Structure
REQ-030 SHALL place the state enum, AXI resp codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and the prot constants in package picorv32_axi_pkg.
REQ-031 SHALL implement the watchdog as sub-module picorv32_axi_wdog (enable, clear, expire).

Verification
REQ-032 Bench SHALL cover write 0x100/0xDEADBEEF/strb 0xF, awready 1 cycle before wready -> one W handshake, bready, mem_ready one cycle after bvalid, mem_error=0.
REQ-033 Bench SHALL cover read 0x200 with mem_instr=1 -> arprot=3'b100; rdata 0x12345678 appears on mem_rdata together with the mem_ready pulse.
REQ-034 Bench SHALL cover a read answered with rresp=2'b10 -> mem_error=1 during mem_ready.
REQ-035 Bench SHALL cover TIMEOUT_CYCLES=8 with arready held low -> mem_ready+mem_error 8 cycles into RADDR, rdata=0xFFFFFFFF, arvalid still high, IDLE after late rvalid.
REQ-036 Bench SHALL cover DATA_WIDTH=64 write with wstrb 0xF0 -> wdata/wstrb passed unchanged.
REQ-037 Bench SHALL cover reset asserted in RDATA -> all outputs 0 next cycle, no mem_ready.
